neuron_mac_ctrl: RTL and testbench

NEURON_MAC_CTRL -- requirements
Module: neuron_mac_ctrl

---
 rtl/neuron_mac_ctrl_if.sv | 32 +++
 rtl/neuron_mac_ctrl.sv | 117 +++++++++++
 tb/tb_neuron_mac_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_ctrl_if.sv
// Operand-fetch, multiplier and result signals of one neuron MAC controller.
// The slave modport is the controller; the master side is memory, multiplier and host.
interface neuron_mac_ctrl_if #(
    parameter int N     = 16,
    parameter int ACC_W = 20
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic                    start;
    logic                    relu_en;
    logic                    rd_en;
    logic [AW-1:0]           rd_addr;
    logic [7:0]              x_data;
    logic [7:0]              w_data;
    logic [7:0]              mult_a;
    logic [7:0]              mult_b;
    logic [14:0]             mult_p;
    logic                    busy;
    logic                    done;
    logic signed [ACC_W-1:0] result;
    logic [7:0]              result_sm;

    modport slave (
        input  start, relu_en, x_data, w_data, mult_p,
        output rd_en, rd_addr, mult_a, mult_b, busy, done, result, result_sm
    );

    modport master (
        output start, relu_en, x_data, w_data, mult_p,
        input  rd_en, rd_addr, mult_a, mult_b, busy, done, result, result_sm
    );
endinterface

// File: rtl/neuron_mac_ctrl.sv
// Sequential multiply-accumulate neuron: one sign-magnitude term per 3 cycles,
// saturating accumulator, optional ReLU and 8-bit sign-magnitude quantisation.
module neuron_mac_ctrl #(
    parameter int N     = 16,
    parameter int ACC_W = 20,
    parameter int SHIFT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    neuron_mac_ctrl_if.slave   bus
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_MULT, S_ACC, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [AW-1:0]           r_idx;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_relu;
    logic [7:0]              r_mult_a;
    logic [7:0]              r_mult_b;
    logic signed [ACC_W-1:0] r_result;
    logic [7:0]              r_result_sm;

    logic                    w_last;
    logic [ACC_W:0]          w_mag_ext;
    logic signed [ACC_W:0]   w_prod;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W-1:0] w_acc_sat;
    logic signed [ACC_W-1:0] w_final;
    logic signed [ACC_W-1:0] w_shifted;
    logic [ACC_W:0]          w_abs;
    logic [6:0]              w_mag7;
    logic [7:0]              w_final_sm;

    assign w_last = (r_idx == AW'(N - 1));

    // One extra bit of headroom makes overflow detectable from the top two bits.
    assign w_mag_ext = (ACC_W + 1)'(bus.mult_p[13:0]);
    assign w_prod    = bus.mult_p[14] ? -$signed(w_mag_ext) : $signed(w_mag_ext);
    assign w_sum     = $signed({r_acc[ACC_W-1], r_acc}) + w_prod;

    always_comb begin
        w_acc_sat = w_sum[ACC_W-1:0];
        if (w_sum[ACC_W] != w_sum[ACC_W-1])
            w_acc_sat = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end

    assign w_final   = (r_relu && w_acc_sat[ACC_W-1]) ? '0 : w_acc_sat;
    assign w_shifted = w_final >>> SHIFT;
    assign w_abs     = w_shifted[ACC_W-1] ? -$signed({w_shifted[ACC_W-1], w_shifted})
                                          : $signed({w_shifted[ACC_W-1], w_shifted});
    assign w_mag7    = (w_abs > (ACC_W + 1)'(127)) ? 7'd127 : w_abs[6:0];
    assign w_final_sm = (w_mag7 == 7'd0) ? 8'h00 : {w_shifted[ACC_W-1], w_mag7};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_READ;
            S_READ:  w_state_next = S_MULT;
            S_MULT:  w_state_next = S_ACC;
            S_ACC:   w_state_next = w_last ? S_DONE : S_READ;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_acc       <= '0;
            r_relu      <= 1'b0;
            r_mult_a    <= 8'h00;
            r_mult_b    <= 8'h00;
            r_result    <= '0;
            r_result_sm <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_idx  <= '0;
                    r_acc  <= '0;
                    r_relu <= bus.relu_en;
                end
                S_MULT: begin
                    r_mult_a <= bus.x_data;
                    r_mult_b <= bus.w_data;
                end
                S_ACC: begin
                    r_acc <= w_acc_sat;
                    // Results are captured on the last add so they are valid alongside done.
                    if (w_last) begin
                        r_result    <= w_final;
                        r_result_sm <= w_final_sm;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_en     = (r_state == S_READ);
    assign bus.rd_addr   = r_idx;
    assign bus.mult_a    = r_mult_a;
    assign bus.mult_b    = r_mult_b;
    assign bus.busy      = (r_state == S_READ) || (r_state == S_MULT) || (r_state == S_ACC);
    assign bus.done      = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.result_sm = r_result_sm;
endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Directed bench for neuron_mac_ctrl with N=4: a 20-bit and a 16-bit accumulator
// instance run in lockstep against a behavioural operand memory and multiplier.
module tb_neuron_mac_ctrl;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0] xmem [N];
    logic [7:0] wmem [N];

    neuron_mac_ctrl_if #(.N(N), .ACC_W(20)) mif ();
    neuron_mac_ctrl_if #(.N(N), .ACC_W(16)) mif16 ();

    neuron_mac_ctrl #(.N(N), .ACC_W(20), .SHIFT(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif.slave)
    );

    neuron_mac_ctrl #(.N(N), .ACC_W(16), .SHIFT(0)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sign-magnitude multiplier model.
    logic [13:0] mag_a;
    logic [13:0] mag_b;
    assign mag_a = {7'b0, mif.mult_a[6:0]} * {7'b0, mif.mult_b[6:0]};
    assign mag_b = {7'b0, mif16.mult_a[6:0]} * {7'b0, mif16.mult_b[6:0]};
    assign mif.mult_p   = {mif.mult_a[7] ^ mif.mult_b[7], mag_a};
    assign mif16.mult_p = {mif16.mult_a[7] ^ mif16.mult_b[7], mag_b};

    // Operand memory: data appears half a cycle after the read strobe and is held.
    always @(negedge clk) begin
        if (mif.rd_en) begin
            mif.x_data = xmem[mif.rd_addr];
            mif.w_data = wmem[mif.rd_addr];
        end
        if (mif16.rd_en) begin
            mif16.x_data = xmem[mif16.rd_addr];
            mif16.w_data = wmem[mif16.rd_addr];
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        mif.start   = v;
        mif16.start = v;
    endtask

    task automatic load(input logic [7:0] xv, input logic [7:0] wv);
        for (int i = 0; i < N; i++) begin
            xmem[i] = xv;
            wmem[i] = wv;
        end
    endtask

    // One evaluation; negedge n after the accepting edge lies in cycle n.
    task automatic run(input string name, input logic [7:0] xv, input logic [7:0] wv,
                       input logic relu, input bit restarts,
                       input int exp_res, input int exp_sm, input int exp_res16);
        int done_cyc;
        int done_cnt;
        done_cyc = 0;
        done_cnt = 0;
        load(xv, wv);
        @(negedge clk);
        set_start(1'b1);
        mif.relu_en   = relu;
        mif16.relu_en = relu;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            set_start(restarts && (n == 3 || n == 13));
            if (n == 1) check({name, " busy_c1"}, int'(mif.busy), 1);
            if (n == 4) begin
                check({name, " rd_en_c4"}, int'(mif.rd_en), 1);
                check({name, " rd_addr_c4"}, int'(mif.rd_addr), 1);
            end
            if (n == 5) check({name, " rd_en_c5"}, int'(mif.rd_en), 0);
            if (mif.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = n;
            end
        end
        set_start(1'b0);
        check({name, " done_cycle"}, done_cyc, 3 * N + 1);
        check({name, " done_count"}, done_cnt, 1);
        check({name, " busy_end"}, int'(mif.busy), 0);
        check({name, " result"}, int'(mif.result), exp_res);
        check({name, " result_sm"}, int'(mif.result_sm), exp_sm);
        check({name, " result16"}, int'(mif16.result), exp_res16);
        $display("run %s x=%02h w=%02h relu=%0d: done@%0d result=%0d sm=%02h result16=%0d",
                 name, xv, wv, relu, done_cyc, mif.result, mif.result_sm, mif16.result);
    endtask

    initial begin
        int done_seen;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_start(1'b0);
        mif.relu_en   = 1'b0;
        mif16.relu_en = 1'b0;
        mif.x_data = 8'h00; mif.w_data = 8'h00;
        mif16.x_data = 8'h00; mif16.w_data = 8'h00;
        load(8'h00, 8'h00);
        repeat (2) @(negedge clk);
        check("rst busy", int'(mif.busy), 0);
        check("rst done", int'(mif.done), 0);
        check("rst rd_en", int'(mif.rd_en), 0);
        check("rst rd_addr", int'(mif.rd_addr), 0);
        check("rst mult_a", int'(mif.mult_a), 0);
        check("rst result", int'(mif.result), 0);
        check("rst result_sm", int'(mif.result_sm), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run("pos", 8'h02, 8'h04, 1'b0, 1'b0, 32, 8'h20, 32);
        run("neg", 8'h82, 8'h04, 1'b0, 1'b0, -32, 8'hA0, -32);
        run("relu", 8'h82, 8'h04, 1'b1, 1'b0, 0, 8'h00, 0);
        run("relu_pos", 8'h02, 8'h04, 1'b1, 1'b0, 32, 8'h20, 32);
        run("negzero", 8'h80, 8'h85, 1'b0, 1'b0, 0, 8'h00, 0);
        run("restart", 8'h02, 8'h04, 1'b0, 1'b1, 32, 8'h20, 32);
        run("max", 8'h7F, 8'h7F, 1'b0, 1'b0, 64516, 8'h7F, 32767);
        run("minsat", 8'hFF, 8'h7F, 1'b0, 1'b0, -64516, 8'hFF, -32768);

        // Reset during the second term abandons the run.
        load(8'h02, 8'h04);
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            set_start(1'b0);
        end
        rst_n = 1'b0;
        #1;
        check("midrst busy", int'(mif.busy), 0);
        check("midrst rd_addr", int'(mif.rd_addr), 0);
        check("midrst mult_a", int'(mif.mult_a), 0);
        check("midrst result", int'(mif.result), 0);
        check("midrst result_sm", int'(mif.result_sm), 0);
        done_seen = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (mif.done) done_seen++;
        end
        check("midrst no_done", done_seen, 0);
        $display("run midrst: reset during term 2, dones after release=%0d", done_seen);
        run("after_rst", 8'h02, 8'h04, 1'b0, 1'b0, 32, 8'h20, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
